// File: rtl/pwm_gen.sv
// Dual-motor PWM generator: captures SPI command bytes on the falling edge of load,
// applies them at PWM period boundaries and forces safe outputs when commands stop arriving.
module pwm_gen #(
    parameter int PRESCALE = 4,
    parameter int TIMEOUT  = 4800000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] motor1,
    input  logic [7:0] motor2,
    output logic       pwm1,
    output logic       pwm2,
    output logic       dir1,
    output logic       dir2,
    output logic       stale,
    output logic       update
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

    logic          sync0, sync1, hist;
    logic [PW-1:0] pre;
    logic [6:0]    cnt;
    logic [7:0]    p1, p2, a1, a2;
    logic [WW-1:0] wd;
    logic          pwm1_q, pwm2_q, dir1_q, dir2_q;
    logic          fall, tick, boundary;

    assign fall     = hist & ~sync1;
    assign tick     = (pre == PRE_MAX);
    assign boundary = tick && (cnt == 7'd126);

    // Watchdog state is the saturated counter itself, so a capture clears it in the same edge.
    assign stale  = (wd == WD_MAX);
    assign update = fall & reset_n;

    assign pwm1 = pwm1_q & ~stale;
    assign pwm2 = pwm2_q & ~stale;
    assign dir1 = dir1_q & ~stale;
    assign dir2 = dir2_q & ~stale;

    // NOTE: every register below uses <= so all of them sample pre-edge values;
    // the same-cycle capture/boundary case relies on a1 taking the old p1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            hist   <= 1'b0;
            pre    <= '0;
            cnt    <= '0;
            p1     <= '0;
            p2     <= '0;
            a1     <= '0;
            a2     <= '0;
            wd     <= '0;
            pwm1_q <= 1'b0;
            pwm2_q <= 1'b0;
            dir1_q <= 1'b0;
            dir2_q <= 1'b0;
        end else begin
            sync0 <= load;
            sync1 <= sync0;
            hist  <= sync1;

            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                cnt <= (cnt == 7'd126) ? 7'd0 : cnt + 7'd1;

            if (fall)
                wd <= '0;
            else if (!stale)
                wd <= wd + 1'b1;

            if (fall) begin
                p1 <= motor1;
                p2 <= motor2;
            end else if (stale) begin
                p1 <= '0;
                p2 <= '0;
            end

            // Stale wins over the boundary so a stale frame can never reach the active set.
            if (stale) begin
                a1 <= '0;
                a2 <= '0;
            end else if (boundary) begin
                a1 <= p1;
                a2 <= p2;
            end

            pwm1_q <= (cnt < a1[6:0]);
            pwm2_q <= (cnt < a2[6:0]);
            dir1_q <= a1[7];
            dir2_q <= a2[7];
        end
    end

endmodule
